// File: rtl/tx_mac_control_pkg.sv
// Shared constants, state encoding and GMII beat type for the transmit MAC.
package tx_mac_control_pkg;

   localparam int unsigned DATA_WIDTH = 8;
   localparam int unsigned BYTE_CNT_W = 11;
   localparam int unsigned CNT_W      = 8;

   localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
   localparam logic [7:0]  SFD_BYTE        = 8'hD5;
   localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;
   localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, IFG} tx_state_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic                  en;
      logic                  er;
   } gmii_tx_t;

endpackage

// File: rtl/tx_mac_control_crc32_byte_update.sv
// Reflected CRC-32 (IEEE 802.3) advanced by one byte, LSB first; shared with the RX FCS check.
module crc32_byte_update
   import tx_mac_control_pkg::*;
(
   input  logic [31:0] crc_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] crc_o
);

   always_comb begin
      crc_o = crc_i ^ {24'h00_0000, byte_i};
      for (int i = 0; i < 8; i++) begin
         crc_o = crc_o[0] ? ((crc_o >> 1) ^ CRC32_POLY_REFL) : (crc_o >> 1);
      end
   end

endmodule

// File: rtl/tx_mac_control.sv
// GMII transmit MAC: preamble, SFD, data, optional pad, CRC-32 FCS, then inter-frame gap.
// Zero padding of short frames is enabled by defining TX_AUTO_PAD_EN.
module tx_mac_control
   import tx_mac_control_pkg::*;
#(
   parameter int unsigned MIN_FRAME_BYTES = 60,
   parameter int unsigned MAX_FRAME_BYTES = 1514,
   parameter int unsigned PREAMBLE_BYTES  = 7,
   parameter int unsigned IFG_BYTES       = 12
) (
   input  logic                  gmii_tx_clk_i,
   input  logic                  gmii_tx_rst_n,
   input  logic [DATA_WIDTH-1:0] tx_data_i,
   input  logic                  tx_valid_i,
   input  logic                  tx_last_i,
   output logic                  tx_ready_o,
   output logic [DATA_WIDTH-1:0] gmii_tx_data_o,
   output logic                  gmii_tx_en_o,
   output logic                  gmii_tx_er_o,
   output logic                  tx_done_o,
   output logic                  tx_abort_o
);

`ifdef TX_AUTO_PAD_EN
   localparam bit PAD_EN = 1'b1;
`else
   localparam bit PAD_EN = 1'b0;
`endif

   tx_state_t             state, state_nxt;
   logic [CNT_W-1:0]      cnt, cnt_nxt;
   logic [BYTE_CNT_W-1:0] byte_cnt, byte_cnt_nxt;
   logic [31:0]           crc, crc_nxt, crc_upd, fcs_word;
   logic [7:0]            crc_byte;
   gmii_tx_t              gmii_q, gmii_nxt;
   logic                  done_q, done_nxt, abort_q, abort_nxt;

   assign tx_ready_o     = (state == DATA);
   assign gmii_tx_data_o = gmii_q.data;
   assign gmii_tx_en_o   = gmii_q.en;
   assign gmii_tx_er_o   = gmii_q.er;
   assign tx_done_o      = done_q;
   assign tx_abort_o     = abort_q;

   assign crc_byte = (state == PAD) ? 8'h00 : tx_data_i;
   assign fcs_word = ~crc;

   crc32_byte_update u_crc (
      .crc_i  (crc),
      .byte_i (crc_byte),
      .crc_o  (crc_upd)
   );

   // State and registered GMII outputs
   always_ff @(posedge gmii_tx_clk_i or negedge gmii_tx_rst_n) begin
      if (!gmii_tx_rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         byte_cnt <= '0;
         crc      <= CRC32_INIT;
         gmii_q   <= '0;
         done_q   <= 1'b0;
         abort_q  <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         byte_cnt <= byte_cnt_nxt;
         crc      <= crc_nxt;
         gmii_q   <= gmii_nxt;
         done_q   <= done_nxt;
         abort_q  <= abort_nxt;
      end
   end

   // The IDLE start cycle registers the first preamble byte, so PRE spans PREAMBLE_BYTES-1 cycles
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      byte_cnt_nxt = byte_cnt;
      crc_nxt      = crc;
      gmii_nxt     = '0;
      done_nxt     = 1'b0;
      abort_nxt    = 1'b0;

      case (state)
         IDLE: begin
            cnt_nxt      = '0;
            byte_cnt_nxt = '0;
            crc_nxt      = CRC32_INIT;
            if (tx_valid_i) begin
               gmii_nxt  = '{data: PREAMBLE_BYTE, en: 1'b1, er: 1'b0};
               state_nxt = PRE;
            end
         end

         PRE: begin
            gmii_nxt = '{data: PREAMBLE_BYTE, en: 1'b1, er: 1'b0};
            if (cnt == CNT_W'(PREAMBLE_BYTES - 2)) begin
               cnt_nxt   = '0;
               state_nxt = SFD;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end

         SFD: begin
            gmii_nxt  = '{data: SFD_BYTE, en: 1'b1, er: 1'b0};
            state_nxt = DATA;
         end

         DATA: begin
            // Underrun, or a byte beyond the maximum length, ends the frame with an error beat
            if (!tx_valid_i || byte_cnt == BYTE_CNT_W'(MAX_FRAME_BYTES)) begin
               gmii_nxt  = '{data: 8'h00, en: 1'b1, er: 1'b1};
               abort_nxt = 1'b1;
               cnt_nxt   = '0;
               state_nxt = IFG;
            end else begin
               gmii_nxt     = '{data: tx_data_i, en: 1'b1, er: 1'b0};
               byte_cnt_nxt = byte_cnt + BYTE_CNT_W'(1);
               crc_nxt      = crc_upd;
               if (tx_last_i) begin
                  cnt_nxt   = '0;
                  state_nxt = (PAD_EN && (byte_cnt_nxt < BYTE_CNT_W'(MIN_FRAME_BYTES))) ? PAD : FCS;
               end
            end
         end

         PAD: begin
            gmii_nxt     = '{data: 8'h00, en: 1'b1, er: 1'b0};
            byte_cnt_nxt = byte_cnt + BYTE_CNT_W'(1);
            crc_nxt      = crc_upd;
            if (byte_cnt_nxt == BYTE_CNT_W'(MIN_FRAME_BYTES)) begin
               state_nxt = FCS;
            end
         end

         FCS: begin
            gmii_nxt = '{data: fcs_word[{cnt[1:0], 3'b000} +: 8], en: 1'b1, er: 1'b0};
            if (cnt[1:0] == 2'd3) begin
               done_nxt  = 1'b1;
               cnt_nxt   = '0;
               state_nxt = IFG;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end

         IFG: begin
            if (cnt == CNT_W'(IFG_BYTES - 1)) begin
               cnt_nxt   = '0;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end

         default: state_nxt = IDLE;
      endcase
   end

endmodule
